// File: rtl/pe_row_if.sv
// Bundle of the PE row's control, weight-stream, activation and partial-sum signals.
// The master side drives the row inputs; the slave side is the PE row itself.
interface pe_row_if #(
    parameter int NUM = 16,
    parameter int DW  = 32,
    parameter int AW  = 64
);
    logic              EN;
    logic              OPSEL;
    logic              W_LOAD_START;
    logic [DW-1:0]     W_IN;
    logic              W_IN_VALID;
    logic [DW-1:0]     W_OUT;
    logic              W_OUT_VALID;
    logic              W_DONE;
    logic [DW-1:0]     act_in;
    logic              act_in_valid;
    logic              act_ready;
    logic [NUM*AW-1:0] in_sum;
    logic [NUM*AW-1:0] out_sum;
    logic [NUM-1:0]    out_valid;

    modport master (
        output EN, OPSEL, W_LOAD_START, W_IN, W_IN_VALID, act_in, act_in_valid, in_sum,
        input  W_OUT, W_OUT_VALID, W_DONE, act_ready, out_sum, out_valid
    );

    modport slave (
        input  EN, OPSEL, W_LOAD_START, W_IN, W_IN_VALID, act_in, act_in_valid, in_sum,
        output W_OUT, W_OUT_VALID, W_DONE, act_ready, out_sum, out_valid
    );
endinterface

// File: rtl/pe_row_pipe.sv
// One row of a systolic MAC array: loads a weight per PE from a word stream,
// then pushes activations through a NUM-stage chain, accumulating into partial sums.
//
// state | meaning
// IDLE  | no weights loaded since reset; activations refused
// LOAD  | capturing weight words into weight[cnt]
// RUN   | row loaded; activations accepted, weight stream forwarded below
module pe_row_pipe #(
    parameter int NUM = 16,
    parameter int DW  = 32,
    parameter int AW  = 64
) (
    input logic     CLK,
    input logic     RESET,
    pe_row_if.slave bus
);
    localparam int CW = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t             state;
    state_t             next_state;
    logic [CW-1:0]      cnt;
    logic [DW-1:0]      weight [NUM];

    logic               act_ready;
    logic               cap_en;
    logic               cap_last;
    logic [CW-1:0]      cap_idx;
    logic               fwd;

    logic [DW-1:0]      chain_a [NUM-1];
    logic [NUM-2:0]     chain_v;
    logic [DW-1:0]      pe_a [NUM];
    logic [NUM-1:0]     pe_v;

    logic signed [2*DW-1:0] prod_s [NUM];
    logic [2*DW-1:0]        prod_u [NUM];
    logic [AW-1:0]          prod_ext [NUM];
    logic [AW-1:0]          mac_sum [NUM];

    logic [AW-1:0]      out_sum_r [NUM];
    logic [NUM-1:0]     out_valid_r;
    logic [DW-1:0]      w_out_r;
    logic               w_out_valid_r;
    logic               w_done_r;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else if (bus.EN) begin
            state <= next_state;
        end
    end

    // Capturing the last word wins, so a one-PE row loaded on the start cycle still finishes.
    always_comb begin
        next_state = state;
        if (cap_last) begin
            next_state = RUN;
        end else if (bus.W_LOAD_START) begin
            next_state = LOAD;
        end
    end

    always_comb begin
        act_ready = (state == RUN);
        cap_idx   = bus.W_LOAD_START ? '0 : cnt;
        cap_en    = bus.W_IN_VALID && (bus.W_LOAD_START || (state == LOAD));
        cap_last  = cap_en && (cap_idx == CW'(NUM - 1));
        fwd       = (state == RUN) && !bus.W_LOAD_START;
    end

    always_comb begin
        pe_a[0] = bus.act_in;
        pe_v[0] = bus.act_in_valid && act_ready;
        for (int i = 1; i < NUM; i++) begin
            pe_a[i] = chain_a[i-1];
            pe_v[i] = chain_v[i-1];
        end
    end

    // Operands are widened before multiplying so the full 2*DW product is kept.
    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            prod_s[i] = $signed((2*DW)'($signed(pe_a[i]))) * $signed((2*DW)'($signed(weight[i])));
            prod_u[i] = (2*DW)'(pe_a[i]) * (2*DW)'(weight[i]);
            if (bus.OPSEL) begin
                prod_ext[i] = AW'(prod_u[i]);
            end else begin
                prod_ext[i] = AW'(prod_s[i]);
            end
            mac_sum[i] = bus.in_sum[i*AW +: AW] + prod_ext[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt           <= '0;
            chain_v       <= '0;
            out_valid_r   <= '0;
            w_out_r       <= '0;
            w_out_valid_r <= 1'b0;
            w_done_r      <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                weight[i]    <= '0;
                out_sum_r[i] <= '0;
            end
        end else if (bus.EN) begin
            if (bus.W_LOAD_START) begin
                cnt <= cap_en ? CW'(1) : '0;
            end else if (cap_en) begin
                cnt <= cnt + CW'(1);
            end
            if (cap_en) begin
                weight[cap_idx] <= bus.W_IN;
            end
            w_done_r      <= cap_last;
            w_out_valid_r <= fwd && bus.W_IN_VALID;
            if (fwd) begin
                w_out_r <= bus.W_IN;
            end
            for (int i = 0; i < NUM - 1; i++) begin
                chain_a[i] <= pe_a[i];
                chain_v[i] <= pe_v[i];
            end
            for (int i = 0; i < NUM; i++) begin
                out_valid_r[i] <= pe_v[i];
                if (pe_v[i]) begin
                    out_sum_r[i] <= mac_sum[i];
                end
            end
        end
    end

    assign bus.act_ready   = act_ready;
    assign bus.W_OUT       = w_out_r;
    assign bus.W_OUT_VALID = w_out_valid_r;
    assign bus.W_DONE      = w_done_r;
    assign bus.out_valid   = out_valid_r;

    for (genvar g = 0; g < NUM; g++) begin : g_lane
        assign bus.out_sum[g*AW +: AW] = out_sum_r[g];
    end
endmodule
